// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register-file geometry, write-back entry layout
// and the write-back arbiter source select.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_MEM = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Write-back request/issue bundle between the producers (load path, ALU),
// the write-back queue and the register file / hazard logic.
interface writeback_queue_if #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH      = 4
) ();

    logic                       flush;
    logic                       mem_valid;
    logic [REG_ADDR_W-1:0]      mem_dst;
    logic [DATA_W-1:0]          mem_data;
    logic                       mem_ready;
    logic                       alu_valid;
    logic [REG_ADDR_W-1:0]      alu_dst;
    logic [DATA_W-1:0]          alu_data;
    logic                       alu_ready;
    logic                       regwrite;
    logic [REG_ADDR_W-1:0]      regdst;
    logic [DATA_W-1:0]          writedata;
    logic [2**REG_ADDR_W-1:0]   busy;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output flush, mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        input  mem_ready, alu_ready, regwrite, regdst, writedata, busy, count
    );

    modport slave (
        input  flush, mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        output mem_ready, alu_ready, regwrite, regdst, writedata, busy, count
    );

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry circular buffer of write-back entries; exports per-entry
// valid/dst so the top level can build the pending-write bitmap.
module wb_fifo #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [REG_ADDR_W-1:0]           push_dst_i,
    input  logic [DATA_W-1:0]               push_data_i,
    input  logic                            pop_i,
    output logic [REG_ADDR_W-1:0]           head_dst_o,
    output logic [DATA_W-1:0]               head_data_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [DEPTH-1:0]                entry_valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_dst_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][REG_ADDR_W-1:0] dst_mem_q;
    logic [DEPTH-1:0][DATA_W-1:0]     data_mem_q;
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic                             do_push, do_pop;

    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign entry_valid_o = valid_q;
    assign entry_dst_o   = dst_mem_q;
    assign head_dst_o    = dst_mem_q[rd_ptr_q];
    assign head_data_o   = data_mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: storage is not reset; valid_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            dst_mem_q[wr_ptr_q]  <= push_dst_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue: arbitrates load/ALU write requests into a FIFO, issues
// one register-file write per cycle and exports the pending-write bitmap.
module writeback_queue #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    writeback_queue_if.slave  wb
);

    import cpu_pkg::*;

    localparam int NREG = 2 ** REG_ADDR_W;

    wb_src_t                          src_sel;
    logic                             push, pop, full, empty;
    logic [REG_ADDR_W-1:0]            push_dst, head_dst;
    logic [DATA_W-1:0]                push_data, head_data;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_dst;
    logic [$clog2(DEPTH):0]           count;

    logic                             regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0]            regdst_q, regdst_d;
    logic [DATA_W-1:0]                writedata_q, writedata_d;
    logic [NREG-1:0]                  busy;

    // Readiness depends on full only, so a same-cycle pop never frees a slot.
    assign wb.mem_ready = !full && !wb.flush;
    assign wb.alu_ready = !full && !wb.flush && !wb.mem_valid;

    always_comb begin
        src_sel   = wb.mem_valid ? WB_SRC_MEM : WB_SRC_ALU;
        push      = (wb.mem_valid && wb.mem_ready) || (wb.alu_valid && wb.alu_ready);
        push_dst  = (src_sel == WB_SRC_MEM) ? wb.mem_dst  : wb.alu_dst;
        push_data = (src_sel == WB_SRC_MEM) ? wb.mem_data : wb.alu_data;
    end

    assign pop = !empty && !wb.flush;

    wb_fifo #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (wb.flush),
        .push_i        (push),
        .push_dst_i    (push_dst),
        .push_data_i   (push_data),
        .pop_i         (pop),
        .head_dst_o    (head_dst),
        .head_data_o   (head_data),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .entry_valid_o (entry_valid),
        .entry_dst_o   (entry_dst)
    );

    // A flush suppresses the pop but lets an already-issued write complete.
    always_comb begin
        regwrite_d  = pop;
        regdst_d    = pop ? head_dst  : regdst_q;
        writedata_d = pop ? head_data : writedata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            regdst_q    <= '0;
            writedata_q <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            regdst_q    <= regdst_d;
            writedata_q <= writedata_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy[entry_dst[i]] = 1'b1;
            end
        end
        if (regwrite_q) begin
            busy[regdst_q] = 1'b1;
        end
    end

    assign wb.regwrite  = regwrite_q;
    assign wb.regdst    = regdst_q;
    assign wb.writedata = writedata_q;
    assign wb.busy      = busy;
    assign wb.count     = count;

endmodule
